// File: rtl/rocket_mem_arbiter.sv
// rtl/rocket_mem_arbiter.sv - round-robin SRAM arbiter with per-port grant lock
// Purpose: shares one single-ported SRAM (read data one cycle after request)
//          between NUM_PORTS requesters, with lockable back-to-back bursts.
// Ports:
//   axi4_mem_0_clock / axi4_mem_0_reset : clock, asynchronous active-high reset
//   req_i, we_i, lock_i                 : per-port request, write enable, grant lock
//   addr_i, be_i, wdata_i               : flattened per-port address, byte enables, write data
//   gnt_o                               : one-hot grant, combinational
//   rvalid_o, rdata_o                   : per-port read strobe, broadcast SRAM read data
//   req_o, we_o, addr_o, be_o, data_o   : SRAM request bus
//   data_i                              : SRAM read data
module rocket_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                  axi4_mem_0_clock,
  input  logic                                  axi4_mem_0_reset,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0]                  lock_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       addr_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       wdata_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  req_o,
  output logic                                  we_o,
  output logic [ADDR_WIDTH-1:0]                 addr_o,
  output logic [DATA_WIDTH/8-1:0]               be_o,
  output logic [DATA_WIDTH-1:0]                 data_o,
  input  logic [DATA_WIDTH-1:0]                 data_i
);

  localparam int                BE_WIDTH = DATA_WIDTH / 8;
  localparam int                IDX_W    = $clog2(NUM_PORTS);
  localparam logic [IDX_W:0]    NP       = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0]  LAST     = IDX_W'(NUM_PORTS - 1);

  logic [IDX_W-1:0]     prio_q, prio_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 locked_q, locked_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

  logic                 owner_req;
  logic                 found;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W:0]       cand;
  logic [NUM_PORTS-1:0] gnt;

  // Grant selection: a locked owner that still requests keeps the bus;
  // otherwise (including a lock owner that just dropped its request) the
  // round-robin scan runs in the same cycle so no idle beat is inserted.
  always_comb begin
    owner_req = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (owner_q == IDX_W'(k) && req_i[k]) owner_req = 1'b1;
    end

    found = 1'b0;
    sel   = '0;
    cand  = '0;
    if (locked_q && owner_req) begin
      found = 1'b1;
      sel   = owner_q;
    end else begin
      // cand is one bit wider than an index so prio_q + i can wrap past the
      // last port without needing a power-of-two port count.
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand = {1'b0, prio_q} + (IDX_W+1)'(i);
        if (cand >= NP) cand = cand - NP;
        if (!found && req_i[cand[IDX_W-1:0]]) begin
          found = 1'b1;
          sel   = cand[IDX_W-1:0];
        end
      end
    end

    gnt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      gnt[k] = found && (sel == IDX_W'(k));
    end
  end

  // Memory bus mux and next-state; everything is zero / held without a grant.
  always_comb begin
    req_o    = found;
    we_o     = 1'b0;
    addr_o   = '0;
    be_o     = '0;
    data_o   = '0;
    prio_d   = prio_q;
    owner_d  = owner_q;
    locked_d = 1'b0;
    rvalid_d = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) begin
        we_o        = we_i[k];
        addr_o      = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        be_o        = be_i[k*BE_WIDTH +: BE_WIDTH];
        data_o      = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        prio_d      = (IDX_W'(k) == LAST) ? '0 : IDX_W'(k + 1);
        owner_d     = IDX_W'(k);
        locked_d    = lock_i[k];
        rvalid_d[k] = !we_i[k];
      end
    end
  end

  always_ff @(posedge axi4_mem_0_clock or posedge axi4_mem_0_reset) begin
    if (axi4_mem_0_reset) begin
      prio_q   <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      rvalid_q <= '0;
    end else begin
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = data_i;

endmodule

// File: tb/tb_rocket_mem_arbiter.sv
// tb/tb_rocket_mem_arbiter.sv - self-checking bench for rocket_mem_arbiter
module tb_rocket_mem_arbiter;

  logic clk;
  logic rst;

  // two-port instance, default widths
  logic [1:0]   req2, we2, lock2, gnt2, rvalid2;
  logic [63:0]  addr2;
  logic [15:0]  be2;
  logic [127:0] wdata2;
  logic [63:0]  rdata2, data_o2, data_i2;
  logic         req_o2, we_o2;
  logic [31:0]  addr_o2;
  logic [7:0]   be_o2;

  // three-port instance, narrow widths
  logic [2:0]   req3, we3, lock3, gnt3, rvalid3;
  logic [47:0]  addr3;
  logic [11:0]  be3;
  logic [95:0]  wdata3;
  logic [31:0]  rdata3, data_o3, data_i3;
  logic         req_o3, we_o3;
  logic [15:0]  addr_o3;
  logic [3:0]   be_o3;

  int errors;
  int checks;

  rocket_mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut2 (
    .axi4_mem_0_clock(clk), .axi4_mem_0_reset(rst),
    .req_i(req2), .we_i(we2), .lock_i(lock2), .addr_i(addr2), .be_i(be2),
    .wdata_i(wdata2), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .req_o(req_o2), .we_o(we_o2), .addr_o(addr_o2), .be_o(be_o2),
    .data_o(data_o2), .data_i(data_i2)
  );

  rocket_mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut3 (
    .axi4_mem_0_clock(clk), .axi4_mem_0_reset(rst),
    .req_i(req3), .we_i(we3), .lock_i(lock3), .addr_i(addr3), .be_i(be3),
    .wdata_i(wdata3), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
    .req_o(req_o3), .we_o(we_o3), .addr_o(addr_o3), .be_o(be_o3),
    .data_o(data_o3), .data_i(data_i3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration: a still-requesting lock owner keeps the bus,
  // otherwise the first requester counting up from prio (mod n) wins.
  function automatic int model_pick(input int n, input int prio, input bit locked,
                                    input int owner, input logic [7:0] req);
    if (locked && req[owner]) return owner;
    for (int i = 0; i < n; i++) begin
      if (req[(prio + i) % n]) return (prio + i) % n;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req2 = '0; we2 = '0; lock2 = '0; addr2 = '0; be2 = '0; wdata2 = '0; data_i2 = '0;
    req3 = '0; we3 = '0; lock3 = '0; addr3 = '0; be3 = '0; wdata3 = '0; data_i3 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #4;
    checks++; if (gnt2 !== 2'b00 || gnt3 !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b/%b want 00/000", gnt2, gnt3); end
    checks++; if (rvalid2 !== 2'b00 || rvalid3 !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b/%b want 00/000", rvalid2, rvalid3); end
    checks++; if ({req_o2, we_o2, addr_o2, be_o2, data_o2} !== 106'd0) begin errors++; $display("FAIL reset_membus: got req=%b addr=%h want all zero", req_o2, addr_o2); end
    // grant stays purely combinational while reset is held
    req2 = 2'b10; addr2 = 64'h0000_0055_0000_0000;
    #1;
    checks++; if (gnt2 !== 2'b10 || req_o2 !== 1'b1 || addr_o2 !== 32'h55) begin errors++; $display("FAIL reset_comb_gnt: got gnt=%b req=%b addr=%h want 10 1 55", gnt2, req_o2, addr_o2); end
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_port();
    do_reset();
    req2 = 2'b10; we2 = 2'b00; addr2 = {32'h100, 32'h0};
    #4;
    checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b want 10", gnt2); end
    checks++; if (addr_o2 !== 32'h100 || req_o2 !== 1'b1 || we_o2 !== 1'b0) begin errors++; $display("FAIL single_bus: got addr=%h req=%b we=%b want 100 1 0", addr_o2, req_o2, we_o2); end
    tick();
    idle_inputs();
    data_i2 = 64'hDEAD_BEEF;
    #4;
    checks++; if (rvalid2 !== 2'b10) begin errors++; $display("FAIL single_rvalid: got %b want 10", rvalid2); end
    checks++; if (rdata2 !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata2); end
    checks++; if (gnt2 !== 2'b00 || req_o2 !== 1'b0) begin errors++; $display("FAIL single_idle: got gnt=%b req=%b want 00 0", gnt2, req_o2); end
    tick();
    // write beat from port 0: full bus forwarded, no read return
    req2 = 2'b01; we2 = 2'b01; addr2 = {32'hFFFF_FFFF, 32'h40}; be2 = 16'hA50F;
    wdata2 = {64'hFFFF_0000_FFFF_0000, 64'h1122_3344_5566_7788};
    #4;
    checks++; if ({we_o2, addr_o2, be_o2, data_o2} !== {1'b1, 32'h40, 8'h0F, 64'h1122_3344_5566_7788}) begin errors++; $display("FAIL write_bus: got we=%b addr=%h be=%h data=%h", we_o2, addr_o2, be_o2, data_o2); end
    tick();
    idle_inputs();
    #4;
    checks++; if (rvalid2 !== 2'b00) begin errors++; $display("FAIL write_no_rvalid: got %b want 00", rvalid2); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    do_reset();
    prev_g = 2'b00;
    for (int c = 0; c < 4; c++) begin
      req2 = 2'b11;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      #4;
      checks++; if (gnt2 !== exp_g) begin errors++; $display("FAIL contention_gnt c%0d: got %b want %b", c, gnt2, exp_g); end
      checks++; if (rvalid2 !== prev_g) begin errors++; $display("FAIL contention_rvalid c%0d: got %b want %b", c, rvalid2, prev_g); end
      prev_g = exp_g;
      tick();
    end
    idle_inputs();
    #4;
    checks++; if (rvalid2 !== 2'b10) begin errors++; $display("FAIL contention_last_rvalid: got %b want 10", rvalid2); end
    tick();
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_g;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req2  = 2'b11;
      // port 1's lock is raised while it waits and must have no effect
      lock2 = {1'(c < 4), 1'(c < 3)};
      exp_g = (c < 4) ? 2'b01 : 2'b10;
      #4;
      checks++; if (gnt2 !== exp_g) begin errors++; $display("FAIL lock_burst_gnt c%0d: got %b want %b", c, gnt2, exp_g); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock_drop();
    do_reset();
    req2 = 2'b01; lock2 = 2'b01;
    #4;
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL lock_drop_first: got %b want 01", gnt2); end
    tick();
    req2 = 2'b11; lock2 = 2'b01;
    #4;
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL lock_drop_held: got %b want 01", gnt2); end
    tick();
    req2 = 2'b10; lock2 = 2'b00;
    #4;
    checks++; if (gnt2 !== 2'b10 || req_o2 !== 1'b1) begin errors++; $display("FAIL lock_drop_handoff: got gnt=%b req=%b want 10 1", gnt2, req_o2); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    logic [2:0] wexp [4];
    wexp = '{3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    addr3 = {16'h2222, 16'h1111, 16'h0000};
    for (int c = 0; c < 4; c++) begin
      req3 = (c == 0) ? 3'b100 : 3'b111;
      #4;
      checks++; if (gnt3 !== wexp[c]) begin errors++; $display("FAIL wrap_gnt c%0d: got %b want %b", c, gnt3, wexp[c]); end
      if (c == 2) begin
        checks++; if (addr_o3 !== 16'h1111) begin errors++; $display("FAIL wrap_addr: got %h want 1111", addr_o3); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req2 = 2'b10; lock2 = 2'b10;
    #4;
    checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL midreset_gnt: got %b want 10", gnt2); end
    tick();
    idle_inputs();
    rst = 1'b1;
    #4;
    checks++; if (rvalid2 !== 2'b00) begin errors++; $display("FAIL midreset_rvalid: got %b want 00", rvalid2); end
    tick();
    rst = 1'b0;
    req2 = 2'b11; lock2 = 2'b11;
    #4;
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL midreset_lock_cleared: got %b want 01", gnt2); end
    checks++; if (rvalid2 !== 2'b00) begin errors++; $display("FAIL midreset_rvalid_after: got %b want 00", rvalid2); end
    tick();
    idle_inputs();
    #4;
    checks++; if (rvalid2 !== 2'b01) begin errors++; $display("FAIL midreset_next_read: got %b want 01", rvalid2); end
    tick();
  endtask

  task automatic test_random();
    int         m_prio, m_owner, m_pend, g;
    bit         m_locked;
    logic [2:0] exp_gnt, exp_rv;
    logic [53:0] exp_bus;
    do_reset();
    m_prio = 0; m_owner = 0; m_pend = -1; m_locked = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        req3[k]  = ($urandom_range(0, 3) != 0);
        we3[k]   = ($urandom_range(0, 2) == 0);
        lock3[k] = $urandom_range(0, 1) != 0;
        addr3[k*16 +: 16]  = 16'($urandom);
        be3[k*4 +: 4]      = 4'($urandom);
        wdata3[k*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 9) == 0) req3 = 3'b000;
      data_i3 = $urandom;
      #4;
      g = model_pick(3, m_prio, m_locked, m_owner, {5'b0, req3});
      exp_gnt = (g < 0) ? 3'b000 : 3'(1 << g);
      exp_rv  = (m_pend < 0) ? 3'b000 : 3'(1 << m_pend);
      exp_bus = (g < 0) ? 54'd0 :
                {1'b1, we3[g], addr3[g*16 +: 16], be3[g*4 +: 4], wdata3[g*32 +: 32]};
      checks++; if (gnt3 !== exp_gnt) begin errors++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt3, exp_gnt); end
      checks++; if ({req_o3, we_o3, addr_o3, be_o3, data_o3} !== exp_bus) begin errors++; $display("FAIL rand_bus c%0d: got %h want %h", c, {req_o3, we_o3, addr_o3, be_o3, data_o3}, exp_bus); end
      checks++; if (rvalid3 !== exp_rv) begin errors++; $display("FAIL rand_rvalid c%0d: got %b want %b", c, rvalid3, exp_rv); end
      if (exp_rv != 3'b000) begin
        checks++; if (rdata3 !== data_i3) begin errors++; $display("FAIL rand_rdata c%0d: got %h want %h", c, rdata3, data_i3); end
      end
      if (g >= 0) begin
        m_pend   = we3[g] ? -1 : g;
        m_prio   = (g + 1) % 3;
        m_locked = lock3[g];
        m_owner  = g;
      end else begin
        m_pend   = -1;
        m_locked = 1'b0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_single_port();
    test_contention();
    test_lock_burst();
    test_lock_drop();
    test_wrap();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rocket_mem_arbiter.md
# rocket_mem_arbiter

Round-robin arbiter sharing the single-ported blackbox SRAM between `NUM_PORTS` requesters, e.g. the AXI-to-memory adapter and a loader/debug port. It sits between the requesters' memory-request buses and the SRAM, whose read data is valid one cycle after a request. It supports per-port lock so AXI bursts issue back-to-back without interleaving. Read data is returned with a per-port valid strobe.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of requesters; legal range 2..8.
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 64: data width; byte-enable width is `DATA_WIDTH/8`.

Ports (vectors are flattened, port k occupies slice k):
- `axi4_mem_0_clock`  in  1  sole clock; all logic is on the rising edge.
- `axi4_mem_0_reset`  in  1  asynchronous, active-high reset.
- `req_i`  in  NUM_PORTS  per-port request.
- `we_i`  in  NUM_PORTS  per-port write enable.
- `lock_i`  in  NUM_PORTS  holds the grant after the current beat.
- `addr_i`  in  NUM_PORTS*ADDR_WIDTH  per-port address.
- `be_i`  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- `wdata_i`  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- `gnt_o`  out  NUM_PORTS  one-hot grant, combinational, same cycle as the request.
- `rvalid_o`  out  NUM_PORTS  read data valid for port k.
- `rdata_o`  out  DATA_WIDTH  `data_i` broadcast to all ports; qualified by `rvalid_o`.
- `req_o`  out  1  SRAM request.
- `we_o`  out  1  SRAM write enable.
- `addr_o`  out  ADDR_WIDTH  SRAM address.
- `be_o`  out  DATA_WIDTH/8  SRAM byte enables.
- `data_o`  out  DATA_WIDTH  SRAM write data.
- `data_i`  in  DATA_WIDTH  SRAM read data, valid the cycle after `req_o && !we_o`.

## Operation
State registers:
- `prio_q`: index of the highest-priority port, 0..NUM_PORTS-1.
- `owner_q`: the locked port index.
- `locked_q`: flag marking that `owner_q` holds the grant.
- `rvalid_q`: NUM_PORTS-bit read-return strobe.

Two arbitration modes:
- UNLOCKED (`locked_q=0`): grant the first port with `req_i` set, searching from `prio_q` upward modulo NUM_PORTS.
- LOCKED (`locked_q=1`):
  - If `req_i[owner_q]=1`, grant `owner_q` unconditionally; other ports wait.
  - If `req_i[owner_q]=0`, release the lock and arbitrate in the same cycle as UNLOCKED.

Memory path:
- With a grant to port g: `req_o=1` and `we_o/addr_o/be_o/data_o` are port g's inputs.
- With no grant: `req_o=0` and all other memory outputs are 0.

State updates on each granted beat to port g:
- `prio_q <= (g+1) mod NUM_PORTS`.
- `locked_q <= lock_i[g]`; `owner_q <= g`.
- `rvalid_q <= onehot(g)` if `we_i[g]=0`, else 0.
- Wrap: g = NUM_PORTS-1 gives `prio_q <= 0`.

With no grant: `rvalid_q <= 0`, `locked_q <= 0`, `prio_q` holds.

Outputs: `rvalid_o = rvalid_q`; `rdata_o = data_i`.

## Timing
- Grant latency: 0 cycles. A granted request reaches the SRAM in the same cycle.
- Read return: `rvalid_o[g]` is high exactly one cycle after the granted read beat, for one cycle per beat.
- Back-to-back reads from different ports: returns follow each other in grant order, one per cycle.
- Throughput: one beat per cycle. A locked port issuing every cycle sees no bubbles.
- Simultaneous lock release and new requests: a lock owner dropping `req_i` loses the grant that cycle. The grant goes, with no idle cycle, to the first other requester from `prio_q`.
- `lock_i` is sampled only on the owner's granted beats. `lock_i` on a non-granted port is ignored.
- Reset (asynchronous assert, any time including mid-burst):
  - `prio_q=0`, `locked_q=0`, `owner_q=0`, `rvalid_q=0`.
  - `gnt_o` follows the combinational rule, so it is 0 whenever no request is present.
  - `req_o=0` when idle. Outputs are driven from the reset state on the first cycle after deassertion.
  - A read in flight at reset produces no `rvalid_o`.
- Invariants:
  - `gnt_o` is one-hot or zero.
  - `rvalid_o` is one-hot or zero.
  - `gnt_o!=0` iff `req_o=1`.

## Test plan
- Single port: port 1 reads address 0x100 with the SRAM returning 0xDEAD_BEEF. Required: `gnt_o=2'b10` and `addr_o=0x100` the same cycle; `rvalid_o=2'b10` with `rdata_o=0xDEAD_BEEF` the next cycle.
- Contention, NUM_PORTS=2, both ports requesting continuously with no lock, from reset. Required grant sequence 0,1,0,1. Each read port's `rvalid_o` fires one cycle after its own grant.
- Lock burst: port 0 issues 4 beats with `lock_i=1` on beats 1-3 and `lock_i=0` on beat 4; port 1 requests throughout. Required: port 0 granted 4 consecutive cycles, port 1 granted on cycle 5.
- Lock release by dropping request: port 0 is locked and drops `req_i` while port 1 requests. Required: port 1 granted in that same cycle, with no idle cycle.
- Wrap-around, NUM_PORTS=3: only port 2 requests, then all ports request. Required: after port 2's grant, the next grant goes to port 0.
- Reset mid-read: assert reset the cycle after a granted read. Required: `rvalid_o=0` and the lock clears; after deassertion, a port 1 lock is not honoured and port 0 wins when both ports request.
